vout_timing_gen: RTL



---
 rtl/vout_pkg.sv | 50 +++++
 rtl/vout_tpg.sv | 51 +++++
 rtl/vout_timing_gen.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/vout_pkg.sv
// ---------------------------------------------------------------------------
// vout_pkg
// Shared definitions for the video-output timing generator:
//   - 640x480@60 raster timing constants (defaults for vout_timing_gen)
//   - PIPE_DEPTH: clocks from counter decode to hs/vs/de/rgb outputs
//   - cnt_t: 12-bit raster counter type
//   - colour-bar RGB constants and a bar-index -> colour helper
// ---------------------------------------------------------------------------
package vout_pkg;

  localparam int TIM_H_ACTIVE = 640;
  localparam int TIM_H_FP     = 16;
  localparam int TIM_H_SYNC   = 96;
  localparam int TIM_H_BP     = 48;
  localparam int TIM_V_ACTIVE = 480;
  localparam int TIM_V_FP     = 10;
  localparam int TIM_V_SYNC   = 2;
  localparam int TIM_V_BP     = 33;

  // Decode -> output latency: one clock for the FIFO read, one for the pixel register.
  localparam int PIPE_DEPTH = 2;

  typedef logic [11:0] cnt_t;

  localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
  localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
  localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] RGB_RED     = 24'hFF0000;
  localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
  localparam logic [23:0] RGB_BLACK   = 24'h000000;

  // Colour of bar number idx, left to right.
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = RGB_WHITE;
      3'd1:    c = RGB_YELLOW;
      3'd2:    c = RGB_CYAN;
      3'd3:    c = RGB_GREEN;
      3'd4:    c = RGB_MAGENTA;
      3'd5:    c = RGB_RED;
      3'd6:    c = RGB_BLUE;
      default: c = RGB_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vout_tpg.sv
// ---------------------------------------------------------------------------
// vout_tpg
// Vertical colour-bar test pattern: eight bars of H_ACTIVE/8 pixels each,
// white, yellow, cyan, green, magenta, red, blue, black. Output is registered,
// so rgb reflects the hcnt presented one clock earlier.
// Ports:
//   clk   in   pixel clock
//   rst_n in   synchronous active-low reset
//   hcnt  in   horizontal counter (12 bits)
//   rgb   out  bar colour for that hcnt (24 bits, registered)
// ---------------------------------------------------------------------------
module vout_tpg
  import vout_pkg::*;
#(
  parameter int H_ACTIVE = TIM_H_ACTIVE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  cnt_t        hcnt,
  output logic [23:0] rgb
);

  localparam int   BAR_W   = ((H_ACTIVE / 8) > 0) ? (H_ACTIVE / 8) : 1;
  localparam cnt_t BAR_W_C = cnt_t'(BAR_W);

  cnt_t       idx_s;
  logic [2:0] bar_s;
  logic [23:0] rgb_r;

  // Bar index from the pixel column; columns past the last bar stay black.
  always_comb begin
    idx_s = hcnt / BAR_W_C;
    if (idx_s > 12'd7) begin
      bar_s = 3'd7;
    end else begin
      bar_s = idx_s[2:0];
    end
  end

  // Colour register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rgb_r <= 24'h000000;
    end else begin
      rgb_r <= bar_colour(bar_s);
    end
  end

  assign rgb = rgb_r;

endmodule

// File: rtl/vout_timing_gen.sv
// ---------------------------------------------------------------------------
// vout_timing_gen
// Raster timing generator and read-FIFO consumer for the DDR frame-buffer
// video output. Generates HS/VS/DE, drives the read side of the controller's
// output FIFO (frame valid + read enable) and re-times FIFO words into pixels.
// Optional build macro: VOUT_TPG_EN adds a colour-bar test pattern selected
// by tpg_en_i (otherwise tpg_en_i is ignored).
// Ports:
//   clk          in   pixel clock, also FIFO read clock
//   rst_n        in   synchronous active-low reset
//   en_i         in   raster enable
//   tpg_en_i     in   test-pattern select
//   fifo_data_i  in   FIFO dout, pixel in [23:0] = {R,G,B}
//   fifo_empty_i in   FIFO empty
//   fval_o       out  read-side frame valid
//   rden_o       out  FIFO read enable
//   hs_o, vs_o   out  syncs (active level HS_POL / VS_POL)
//   de_o         out  data enable
//   rgb_o        out  pixel (24 bits)
//   underflow_o  out  sticky read-while-empty flag, cleared at fval_o rise
// ---------------------------------------------------------------------------
module vout_timing_gen
  import vout_pkg::*;
#(
  parameter int   H_ACTIVE = TIM_H_ACTIVE,
  parameter int   H_FP     = TIM_H_FP,
  parameter int   H_SYNC   = TIM_H_SYNC,
  parameter int   H_BP     = TIM_H_BP,
  parameter int   V_ACTIVE = TIM_V_ACTIVE,
  parameter int   V_FP     = TIM_V_FP,
  parameter int   V_SYNC   = TIM_V_SYNC,
  parameter int   V_BP     = TIM_V_BP,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic        tpg_en_i,
  input  logic [31:0] fifo_data_i,
  input  logic        fifo_empty_i,
  output logic        fval_o,
  output logic        rden_o,
  output logic        hs_o,
  output logic        vs_o,
  output logic        de_o,
  output logic [23:0] rgb_o,
  output logic        underflow_o
);

  localparam int   H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int   V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam cnt_t H_LAST     = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST     = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_ACT_C    = cnt_t'(H_ACTIVE);
  localparam cnt_t V_ACT_C    = cnt_t'(V_ACTIVE);
  localparam cnt_t H_SYNC_BEG = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t H_SYNC_END = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t V_SYNC_BEG = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t V_SYNC_END = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

  cnt_t hcnt_r, vcnt_r;
  cnt_t hcnt_nxt_s, vcnt_nxt_s;
  logic active_nxt_s, fval_nxt_s;
  logic hs_lvl_s, vs_lvl_s;
  logic rden_r, fval_r, underflow_r;
  logic uf_set_s, fval_rise_s;
  logic [PIPE_DEPTH-1:0] hs_pipe_r, vs_pipe_r, de_pipe_r;
  logic rd_d1_r, empty_d1_r;
  logic [23:0] fifo_rgb_s, rgb_nxt_s, rgb_r;
  logic unused_s;

  // Next raster position; disabled raster parks at the start of the front porch.
  always_comb begin
    hcnt_nxt_s = 12'd0;
    vcnt_nxt_s = V_ACT_C;
    if (en_i) begin
      if (hcnt_r == H_LAST) begin
        hcnt_nxt_s = 12'd0;
        if (vcnt_r == V_LAST) begin
          vcnt_nxt_s = 12'd0;
        end else begin
          vcnt_nxt_s = vcnt_r + 12'd1;
        end
      end else begin
        hcnt_nxt_s = hcnt_r + 12'd1;
        vcnt_nxt_s = vcnt_r;
      end
    end else begin
      hcnt_nxt_s = 12'd0;
      vcnt_nxt_s = V_ACT_C;
    end
  end

  // Decodes of the next position, registered so rden_o/fval_o line up with
  // the counter registers. fval is low through front porch and sync only, so
  // its rise at the back porch gives the controller V_BP lines to prefill.
  always_comb begin
    active_nxt_s = (hcnt_nxt_s < H_ACT_C) && (vcnt_nxt_s < V_ACT_C);
    fval_nxt_s   = !((vcnt_nxt_s >= V_ACT_C) && (vcnt_nxt_s < V_SYNC_END));
    fval_rise_s  = fval_nxt_s && !fval_r;
    uf_set_s     = rden_r && fifo_empty_i;
  end

  // Sync decodes of the current position, expressed as output levels.
  always_comb begin
    if ((hcnt_r >= H_SYNC_BEG) && (hcnt_r < H_SYNC_END)) begin
      hs_lvl_s = HS_POL;
    end else begin
      hs_lvl_s = ~HS_POL;
    end
    if ((vcnt_r >= V_SYNC_BEG) && (vcnt_r < V_SYNC_END)) begin
      vs_lvl_s = VS_POL;
    end else begin
      vs_lvl_s = ~VS_POL;
    end
  end

  // Raster counters, read enable and frame valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcnt_r <= 12'd0;
      vcnt_r <= V_ACT_C;
      rden_r <= 1'b0;
      fval_r <= 1'b0;
    end else begin
      hcnt_r <= hcnt_nxt_s;
      vcnt_r <= vcnt_nxt_s;
      rden_r <= active_nxt_s;
      fval_r <= fval_nxt_s;
    end
  end

  // HS/VS/DE delay lines matching the FIFO read + pixel register latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hs_pipe_r <= {PIPE_DEPTH{~HS_POL}};
      vs_pipe_r <= {PIPE_DEPTH{~VS_POL}};
      de_pipe_r <= '0;
    end else begin
      hs_pipe_r <= {hs_pipe_r[PIPE_DEPTH-2:0], hs_lvl_s};
      vs_pipe_r <= {vs_pipe_r[PIPE_DEPTH-2:0], vs_lvl_s};
      de_pipe_r <= {de_pipe_r[PIPE_DEPTH-2:0], rden_r};
    end
  end

  // Stage 1: remember whether a read was issued and whether it hit an empty FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_d1_r    <= 1'b0;
      empty_d1_r <= 1'b0;
    end else begin
      rd_d1_r    <= rden_r;
      empty_d1_r <= fifo_empty_i;
    end
  end

  // FIFO pixel; a read that found the FIFO empty yields black.
  always_comb begin
    if (rd_d1_r && !empty_d1_r) begin
      fifo_rgb_s = fifo_data_i[23:0];
    end else begin
      fifo_rgb_s = 24'h000000;
    end
  end

`ifdef VOUT_TPG_EN
  logic [23:0] tpg_rgb_s;

  vout_tpg #(
    .H_ACTIVE (H_ACTIVE)
  ) u_tpg (
    .clk   (clk),
    .rst_n (rst_n),
    .hcnt  (hcnt_r),
    .rgb   (tpg_rgb_s)
  );

  // Pixel source select; FIFO reads continue underneath the test pattern.
  always_comb begin
    rgb_nxt_s = fifo_rgb_s;
    if (tpg_en_i) begin
      rgb_nxt_s = rd_d1_r ? tpg_rgb_s : 24'h000000;
    end else begin
      rgb_nxt_s = fifo_rgb_s;
    end
  end
`else
  // Pixel source: always the FIFO.
  always_comb begin
    rgb_nxt_s = fifo_rgb_s;
  end
`endif

  // Stage 2: pixel register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rgb_r <= 24'h000000;
    end else begin
      rgb_r <= rgb_nxt_s;
    end
  end

  // Sticky underflow; a set in the same clock as the frame-start clear wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      underflow_r <= 1'b0;
    end else if (uf_set_s) begin
      underflow_r <= 1'b1;
    end else if (fval_rise_s) begin
      underflow_r <= 1'b0;
    end else begin
      underflow_r <= underflow_r;
    end
  end

  // Upper FIFO byte carries no pixel data; tpg_en_i is unused without the pattern.
  assign unused_s = ^{fifo_data_i[31:24], tpg_en_i};

  assign fval_o      = fval_r;
  assign rden_o      = rden_r;
  assign hs_o        = hs_pipe_r[PIPE_DEPTH-1];
  assign vs_o        = vs_pipe_r[PIPE_DEPTH-1];
  assign de_o        = de_pipe_r[PIPE_DEPTH-1];
  assign rgb_o       = rgb_r;
  assign underflow_o = underflow_r;

endmodule
